// File: rtl/fifo_line_reader.sv
// Read-side consumer for the 24-bit line FIFOs: drains one line of LINE_LEN words
// per start pulse onto a valid/ready stream, absorbing FIFO read latency in a skid buffer.
module fifo_line_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_LEN   = 256,
    parameter int OUT_REG    = 0,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk_tb,
    input  logic                  tb_rst,
    input  logic                  start,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   words_issued,
    output logic                  line_done
);

    localparam int LAT   = 1 + OUT_REG;
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0] LEN      = (ADDR_WIDTH + 1)'(LINE_LEN);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(LINE_LEN - 1);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(SKID_DEPTH - 1);
    localparam logic [CNT_W:0]      OCC_MAX  = (CNT_W + 1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [LAT-1:0]        rd_pipe;
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      skid_count;
    logic [CNT_W:0]        occupancy;
    logic [ADDR_WIDTH:0]   words_out;
    logic                  start_line;
    logic                  push;
    logic                  pop;

    // Reads in flight already own a skid slot, so they count against the depth.
    assign occupancy  = {1'b0, skid_count} + (CNT_W + 1)'($countones(rd_pipe));
    assign start_line = (state == IDLE) && start;
    assign push       = rd_pipe[LAT-1];
    assign pop        = m_valid && m_ready;

    assign m_valid    = (skid_count != '0);
    assign m_data     = skid_mem[rd_ptr];
    assign m_last     = m_valid && (words_out == LAST_IDX);
    assign busy       = (state == READ) || (state == FLUSH);
    assign line_done  = (state == DONE);
    assign fifo_rd_en = (state == READ) && !fifo_empty &&
                        (words_issued < LEN) && (occupancy < OCC_MAX);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (words_issued == LEN) state_next = FLUSH;
            FLUSH:   if (pop && m_last && (rd_pipe == '0)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            state        <= IDLE;
            words_issued <= '0;
            words_out    <= '0;
            rd_pipe      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            skid_count   <= '0;
            skid_mem     <= '{default: '0};
        end else begin
            state   <= state_next;
            rd_pipe <= LAT'({rd_pipe, fifo_rd_en});

            if (start_line) begin
                words_issued <= '0;
                words_out    <= '0;
            end else begin
                if (fifo_rd_en) words_issued <= words_issued + 1'b1;
                if (pop)        words_out    <= words_out + 1'b1;
            end

            if (push) begin
                skid_mem[wr_ptr] <= fifo_rd_data;
                wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   skid_count <= skid_count + 1'b1;
                2'b01:   skid_count <= skid_count - 1'b1;
                default: skid_count <= skid_count;
            endcase
        end
    end

endmodule

// File: doc/fifo_line_reader.md
Name: fifo_line_reader

Overview:
- Read-side consumer for the 24-bit line FIFOs (Left_FIFO and its siblings).
- On a start pulse it drains exactly LINE_LEN words from the FIFO and presents them on a valid/ready stream.
- Marks the last word of the line with m_last.
- Absorbs the FIFO read latency (OUT_REG 0 or 1) in a small skid buffer, so downstream back-pressure never loses or duplicates a word.

Parameters:
- DATA_WIDTH, 24, FIFO word and stream width.
- ADDR_WIDTH, 8, FIFO address width; line counter is ADDR_WIDTH+1 bits.
- LINE_LEN, 256, words per line; legal range 1..2**ADDR_WIDTH.
- OUT_REG, 0, 1 when the FIFO output register is enabled; read latency = 1+OUT_REG cycles.
- SKID_DEPTH, 4, skid buffer entries; must be >= 2+OUT_REG.

Ports:
- clk_tb  in  1  clock, shared with the FIFO read clock.
- tb_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins one line read.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the LINE_LEN-th word of the line.
- busy  out  1  high from the start accept until the last word handshakes.
- words_issued  out  ADDR_WIDTH+1  FIFO reads issued in the current line.
- line_done  out  1  one-cycle pulse on the cycle after the last handshake.

Behaviour:
- Reset (tb_rst=1, async): all outputs 0; FSM=IDLE; skid buffer empty; outstanding-read count 0.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE: start=1 -> READ; clear words_issued; busy=1 from the next cycle. Start while busy is ignored.
- Read issue rule: fifo_rd_en = (state==READ) && !fifo_empty && (words_issued<LINE_LEN) && (inflight+skid_count < SKID_DEPTH). This rule is combinational, so a read is never issued while empty.
- Data capture:
  - A read accepted at edge N returns fifo_rd_data sampled at edge N+1+OUT_REG.
  - A per-cycle valid shift register of length 1+OUT_REG tracks reads in flight.
  - Captured data is pushed into the skid FIFO.
- Transitions:
  - READ -> FLUSH when words_issued reaches LINE_LEN.
  - FLUSH -> DONE when inflight=0, skid empty, and the last handshake (m_valid && m_ready && m_last) occurs.
  - DONE -> IDLE unconditionally after 1 cycle. line_done=1 during DONE; busy=0 in DONE.
- Stream rules:
  - m_valid = skid not empty; m_data = skid head.
  - The head is popped when m_valid && m_ready.
  - m_data and m_valid are held stable while m_valid && !m_ready.
- m_last: set on the word whose output handshake count equals LINE_LEN; output counter is ADDR_WIDTH+1 bits, reset at start.
- Simultaneous push and pop on the same edge: skid count unchanged; ordering preserved.
- FIFO empty mid-line: reads pause, the state stays READ, and reads resume when empty deasserts; no timeout.
- m_ready low for a long period: at most SKID_DEPTH words are buffered or in flight; fifo_rd_en stays low; no overflow.
- LINE_LEN=2**ADDR_WIDTH: counters do not wrap, because they are ADDR_WIDTH+1 bits wide.
- Reset mid-operation: immediate return to IDLE. Any in-flight FIFO data arriving afterwards is discarded.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and m_ready=1.
- First m_valid appears 2+OUT_REG cycles after start.

Test Plan:
- Basic line: preload FIFO with 1..256, OUT_REG=0, m_ready=1, start -> 256 consecutive words 1..256, m_last only on 256, line_done 1 cycle later, fifo_rd_en never high with empty=1.
- Latency variant: OUT_REG=1 with the same stimulus -> identical data order; first m_valid 3 cycles after start; no duplicates or drops.
- Back-pressure: m_ready toggled 1,0,0,1 pattern -> data held stable while stalled; at most SKID_DEPTH reads outstanding; output still 1..256 in order.
- Starved FIFO: writer supplies 10 words, pauses 50 cycles, then supplies the rest -> reader pauses without error; m_last on word 256; busy high throughout.
- Short line: LINE_LEN=16 with FIFO holding 40 words -> exactly 16 reads issued; 24 remain (empty=0 afterwards); a second start reads words 17..32.
- Reset mid-line: assert tb_rst after 100 words -> all outputs 0 immediately; after release and a fresh start, reading resumes from FIFO contents with a correct m_last count.
